// File: rtl/coffee_pkg.sv
// Shared types and fixed recipe data for the coffee maker control FSM.
package coffee_pkg;

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_e;

  localparam logic [2:0] ING_NONE   = 3'd0;
  localparam logic [2:0] ING_WATER  = 3'd1;
  localparam logic [2:0] ING_COFFEE = 3'd2;
  localparam logic [2:0] ING_MILK   = 3'd3;
  localparam logic [2:0] ING_CHOC   = 3'd4;
  localparam logic [2:0] ING_SUGAR  = 3'd5;

  // Index of the final step for each c_type (length - 1).
  function automatic logic [2:0] recipe_last(input logic [1:0] recipe);
    case (recipe)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      2'd2:    return 3'd4;
      default: return 3'd3;
    endcase
  endfunction

  // Valve bit for code c sits at position c+2; unused codes close everything.
  function automatic logic [7:3] valve_mask(input logic [2:0] code);
    case (code)
      ING_WATER:  return 5'b00001;
      ING_COFFEE: return 5'b00010;
      ING_MILK:   return 5'b00100;
      ING_CHOC:   return 5'b01000;
      ING_SUGAR:  return 5'b10000;
      default:    return 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/coffee_fsm_if.sv
// Panel/timer/valve signal bundle between the coffee FSM and its surroundings.
interface coffee_fsm_if;
  logic       ok;
  logic [1:0] c_type;
  logic       t_expired;
  logic [2:0] ing_type;
  logic       start_timer;
  logic [7:3] ingredientes;

  modport master (output ok, c_type, t_expired,
                  input  ing_type, start_timer, ingredientes);
  modport slave  (input  ok, c_type, t_expired,
                  output ing_type, start_timer, ingredientes);
endinterface

// File: rtl/coffee_recipe_rom.sv
// Combinational recipe table: (recipe, step) -> ingredient code and last-step flag.
module coffee_recipe_rom
  import coffee_pkg::*;
(
  input  logic [1:0] recipe,
  input  logic [2:0] step,
  output logic [2:0] code,
  output logic       last_step
);

  always_comb begin
    code = ING_NONE;
    case (recipe)
      2'd0: case (step)
        3'd0: code = ING_WATER;
        3'd1: code = ING_COFFEE;
        default: code = ING_NONE;
      endcase
      2'd1: case (step)
        3'd0: code = ING_WATER;
        3'd1: code = ING_COFFEE;
        3'd2: code = ING_SUGAR;
        default: code = ING_NONE;
      endcase
      2'd2: case (step)
        3'd0: code = ING_WATER;
        3'd1: code = ING_COFFEE;
        3'd2: code = ING_CHOC;
        3'd3: code = ING_MILK;
        3'd4: code = ING_SUGAR;
        default: code = ING_NONE;
      endcase
      default: case (step)
        3'd0: code = ING_WATER;
        3'd1: code = ING_COFFEE;
        3'd2: code = ING_MILK;
        3'd3: code = ING_SUGAR;
        default: code = ING_NONE;
      endcase
    endcase
  end

  assign last_step = (step == recipe_last(recipe));

endmodule

// File: rtl/coffee_fsm.sv
// Coffee maker sequencer: latches a recipe on ok and steps through its ingredients,
// one valve and one timer pulse per step.
module coffee_fsm
  import coffee_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  coffee_fsm_if.slave  bus
);

  state_e     state_q, state_d;
  logic [1:0] recipe_q, recipe_d;
  logic [2:0] step_q, step_d;
  logic       last_q, last_d;
  logic [2:0] ing_type_q, ing_type_d;
  logic       start_timer_q, start_timer_d;
  logic [7:3] ingredientes_q, ingredientes_d;
  logic [2:0] rom_code;

  // ROM looks at the next (recipe, step) so outputs can be registered; its
  // last_step flag is registered too, giving last-step of the current step.
  coffee_recipe_rom u_rom (
    .recipe    (recipe_d),
    .step      (step_d),
    .code      (rom_code),
    .last_step (last_d)
  );

  always_comb begin
    state_d  = state_q;
    recipe_d = recipe_q;
    step_d   = step_q;
    case (state_q)
      IDLE: if (bus.ok) begin
        state_d  = START;
        recipe_d = bus.c_type;
        step_d   = 3'd0;
      end
      START, WAIT: begin
        if (bus.t_expired) begin
          if (last_q) state_d = DONE;
          else begin
            state_d = START;
            step_d  = step_q + 3'd1;
          end
        end else begin
          state_d = WAIT;
        end
      end
      DONE: if (!bus.ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ing_type_d     = ING_NONE;
    start_timer_d  = 1'b0;
    ingredientes_d = '0;
    if (state_d == START || state_d == WAIT) begin
      ing_type_d     = rom_code;
      ingredientes_d = valve_mask(rom_code);
      start_timer_d  = (state_d == START);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      recipe_q       <= 2'd0;
      step_q         <= 3'd0;
      last_q         <= 1'b0;
      ing_type_q     <= ING_NONE;
      start_timer_q  <= 1'b0;
      ingredientes_q <= '0;
    end else begin
      state_q        <= state_d;
      recipe_q       <= recipe_d;
      step_q         <= step_d;
      last_q         <= last_d;
      ing_type_q     <= ing_type_d;
      start_timer_q  <= start_timer_d;
      ingredientes_q <= ingredientes_d;
    end
  end

  assign bus.ing_type     = ing_type_q;
  assign bus.start_timer  = start_timer_q;
  assign bus.ingredientes = ingredientes_q;

endmodule

// File: tb/tb_coffee_fsm.sv
// Directed vector bench for coffee_fsm: table-driven mocha/espresso run plus
// hand sequences for long waits, c_type changes and mid-recipe reset.
module tb_coffee_fsm;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  coffee_fsm_if bus ();

  coffee_fsm dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       ok;
    logic [1:0] c;
    logic       te;
    logic [2:0] e_ing;
    logic       e_st;
    logic [4:0] e_v;
  } vec_t;

  vec_t vecs[21];

  task automatic apply(input logic r, input logic o, input logic [1:0] c, input logic te,
                       input logic [2:0] e_ing, input logic e_st, input logic [4:0] e_v,
                       input string nm);
    reset = r; bus.ok = o; bus.c_type = c; bus.t_expired = te;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.ing_type, bus.start_timer, bus.ingredientes} !== {e_ing, e_st, e_v}) begin
      errors++;
      $display("FAIL %s: got ing=%0d st=%0b v=%b, want ing=%0d st=%0b v=%b",
               nm, bus.ing_type, bus.start_timer, bus.ingredientes, e_ing, e_st, e_v);
    end
  endtask

  initial begin
    logic [2:0] latte [4];
    logic [4:0] latte_v [4];
    reset = 1'b1; bus.ok = 1'b1; bus.c_type = 2'd0; bus.t_expired = 1'b0;

    //          r  ok c     te  ing  st  valves(7:3)
    vecs[0]  = '{1, 1, 2'd2, 0, 3'd0, 0, 5'b00000};
    vecs[1]  = '{1, 1, 2'd2, 0, 3'd0, 0, 5'b00000};
    vecs[2]  = '{0, 1, 2'd2, 0, 3'd1, 1, 5'b00001};
    vecs[3]  = '{0, 1, 2'd2, 0, 3'd1, 0, 5'b00001};
    vecs[4]  = '{0, 1, 2'd2, 1, 3'd2, 1, 5'b00010};
    vecs[5]  = '{0, 1, 2'd2, 0, 3'd2, 0, 5'b00010};
    vecs[6]  = '{0, 1, 2'd2, 1, 3'd4, 1, 5'b01000};
    vecs[7]  = '{0, 1, 2'd2, 0, 3'd4, 0, 5'b01000};
    vecs[8]  = '{0, 1, 2'd2, 1, 3'd3, 1, 5'b00100};
    vecs[9]  = '{0, 1, 2'd2, 0, 3'd3, 0, 5'b00100};
    vecs[10] = '{0, 1, 2'd2, 1, 3'd5, 1, 5'b10000};
    vecs[11] = '{0, 1, 2'd2, 0, 3'd5, 0, 5'b10000};
    vecs[12] = '{0, 1, 2'd2, 1, 3'd0, 0, 5'b00000};
    vecs[13] = '{0, 1, 2'd2, 0, 3'd0, 0, 5'b00000};
    vecs[14] = '{0, 1, 2'd2, 1, 3'd0, 0, 5'b00000};
    vecs[15] = '{0, 0, 2'd2, 0, 3'd0, 0, 5'b00000};
    vecs[16] = '{0, 0, 2'd2, 1, 3'd0, 0, 5'b00000};
    // t_expired already high in START advances straight to the next step
    vecs[17] = '{0, 1, 2'd0, 0, 3'd1, 1, 5'b00001};
    vecs[18] = '{0, 0, 2'd0, 1, 3'd2, 1, 5'b00010};
    vecs[19] = '{0, 0, 2'd0, 1, 3'd0, 0, 5'b00000};
    vecs[20] = '{0, 0, 2'd0, 0, 3'd0, 0, 5'b00000};

    for (int i = 0; i < 21; i++)
      apply(vecs[i].r, vecs[i].ok, vecs[i].c, vecs[i].te,
            vecs[i].e_ing, vecs[i].e_st, vecs[i].e_v, $sformatf("vec%0d", i));

    // Espresso with a long timer: valve stays on water until the pulse.
    apply(0, 1, 2'd0, 0, 3'd1, 1, 5'b00001, "esp_start");
    for (int i = 0; i < 20; i++)
      apply(0, 0, 2'd0, 0, 3'd1, 0, 5'b00001, $sformatf("esp_wait%0d", i));
    apply(0, 0, 2'd0, 1, 3'd2, 1, 5'b00010, "esp_coffee");
    apply(0, 0, 2'd0, 0, 3'd2, 0, 5'b00010, "esp_coffee_wait");
    apply(0, 0, 2'd0, 1, 3'd0, 0, 5'b00000, "esp_done");
    apply(0, 0, 2'd0, 0, 3'd0, 0, 5'b00000, "esp_idle");

    // Latte latched; c_type switched to espresso right after START.
    latte = '{3'd1, 3'd2, 3'd3, 3'd5};
    latte_v = '{5'b00001, 5'b00010, 5'b00100, 5'b10000};
    apply(0, 1, 2'd3, 0, latte[0], 1, latte_v[0], "latte_start");
    for (int s = 0; s < 4; s++) begin
      apply(0, 0, 2'd0, 0, latte[s], 0, latte_v[s], $sformatf("latte_wait%0d", s));
      if (s < 3)
        apply(0, 0, 2'd0, 1, latte[s+1], 1, latte_v[s+1], $sformatf("latte_step%0d", s + 1));
    end
    apply(0, 0, 2'd0, 1, 3'd0, 0, 5'b00000, "latte_done");
    apply(0, 0, 2'd0, 0, 3'd0, 0, 5'b00000, "latte_idle");

    // Americano reset during the sugar step, then a fresh start.
    apply(0, 1, 2'd1, 0, 3'd1, 1, 5'b00001, "am_start");
    apply(0, 0, 2'd1, 1, 3'd2, 1, 5'b00010, "am_coffee");
    apply(0, 0, 2'd1, 1, 3'd5, 1, 5'b10000, "am_sugar");
    apply(0, 0, 2'd1, 0, 3'd5, 0, 5'b10000, "am_sugar_wait");
    apply(1, 1, 2'd1, 1, 3'd0, 0, 5'b00000, "am_reset");
    apply(0, 0, 2'd1, 1, 3'd0, 0, 5'b00000, "idle_texp");
    apply(0, 1, 2'd1, 0, 3'd1, 1, 5'b00001, "am_restart");
    apply(0, 0, 2'd1, 0, 3'd1, 0, 5'b00001, "am_restart_wait");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
